// File: rtl/rt_pkg.sv
// Shared ray-tracing types: Q16.16 constants, the per-ray hit record and the reducer state.
// The hit_count record field exists only when CLOSEST_HIT_COUNT_EN is defined.
package rt_pkg;

    localparam int RT_IDX_W = 16;
    localparam int RT_ID_W  = 8;

    localparam logic signed [31:0] FIP_ONE = 32'sh0001_0000;
    localparam logic signed [31:0] FIP_MAX = 32'sh7fff_ffff;
    localparam logic signed [31:0] FIP_MIN = 32'sh8000_0000;

    typedef struct packed {
        logic                hit;
        logic signed [31:0]  t;
        logic [RT_IDX_W-1:0] tri_idx;
        logic [RT_ID_W-1:0]  ray_id;
`ifdef CLOSEST_HIT_COUNT_EN
        logic [RT_IDX_W-1:0] hit_count;
`endif
    } hit_rec_t;

    typedef enum logic {IDLE, ACCUM} red_state_t;

endpackage

// File: rtl/hit_rec_fifo.sv
// Small synchronous FIFO of hit records; head is presented directly from the storage registers.
// Push while full is accepted only when a pop frees the slot in the same cycle; otherwise it sets sticky overflow.
module hit_rec_fifo
    import rt_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_push,
    input  hit_rec_t                 i_data,
    input  logic                     i_pop,
    output hit_rec_t                 o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    hit_rec_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            ovf_q;
    logic            full;
    logic            empty;
    logic            pop_ok;
    logic            push_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        pop_ok  = i_pop & ~empty;
        push_ok = i_push & (~full | pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (i_push && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign o_data     = mem_q[rd_ptr_q];
    assign o_valid    = ~empty;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/closest_hit_reducer.sv
// Reduces a per-triangle intersection stream into one closest-hit record per ray, queued in hit_rec_fifo.
// Optional CLOSEST_HIT_COUNT_EN adds o_hit_count (hits per ray). IDX_W/ID_W must match rt_pkg widths.
module closest_hit_reducer
    import rt_pkg::*;
#(
    parameter int IDX_W      = RT_IDX_W,
    parameter int ID_W       = RT_ID_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    input  logic signed [31:0]      i_t,
    input  logic                    i_result,
    input  logic                    i_last,
    input  logic [ID_W-1:0]         i_ray_id,
    output logic                    o_full,
    output logic                    o_overflow,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_hit,
    output logic signed [31:0]      o_t,
    output logic [IDX_W-1:0]        o_tri_idx,
    output logic [ID_W-1:0]         o_ray_id
`ifdef CLOSEST_HIT_COUNT_EN
    ,
    output logic [IDX_W-1:0]        o_hit_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    red_state_t          state_q;
    logic                best_hit_q;
    logic signed [31:0]  best_t_q;
    logic [IDX_W-1:0]    best_idx_q;
    logic [IDX_W-1:0]    tri_cnt_q;
    logic [ID_W-1:0]     ray_id_q;

    logic                best_hit_d;
    logic signed [31:0]  best_t_d;
    logic [IDX_W-1:0]    best_idx_d;
    logic [IDX_W-1:0]    cur_idx;
    logic [ID_W-1:0]     ray_id_d;
    logic                upd;
    logic                push;
    hit_rec_t            rec_d;
    hit_rec_t            head;
    logic [CW-1:0]       fifo_count;

`ifdef CLOSEST_HIT_COUNT_EN
    logic [IDX_W-1:0]    hit_cnt_q;
    logic [IDX_W-1:0]    hit_cnt_d;
`endif

    // The first triangle of a ray starts from a fresh miss record rather than the stale accumulator.
    always_comb begin
        cur_idx    = (state_q == IDLE) ? '0       : tri_cnt_q;
        ray_id_d   = (state_q == IDLE) ? i_ray_id : ray_id_q;
        best_hit_d = (state_q == IDLE) ? 1'b0     : best_hit_q;
        best_t_d   = (state_q == IDLE) ? FIP_MAX  : best_t_q;
        best_idx_d = (state_q == IDLE) ? '0       : best_idx_q;
        upd        = i_result && (i_t < best_t_d);
        if (upd) begin
            best_hit_d = 1'b1;
            best_t_d   = i_t;
            best_idx_d = cur_idx;
        end
`ifdef CLOSEST_HIT_COUNT_EN
        hit_cnt_d = ((state_q == IDLE) ? '0 : hit_cnt_q) + IDX_W'(i_result);
`endif
        rec_d         = '0;
        rec_d.hit     = best_hit_d;
        rec_d.t       = best_t_d;
        rec_d.tri_idx = best_idx_d;
        rec_d.ray_id  = ray_id_d;
`ifdef CLOSEST_HIT_COUNT_EN
        rec_d.hit_count = hit_cnt_d;
`endif
        push = i_valid & i_last;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            best_hit_q <= 1'b0;
            best_t_q   <= '0;
            best_idx_q <= '0;
            tri_cnt_q  <= '0;
            ray_id_q   <= '0;
`ifdef CLOSEST_HIT_COUNT_EN
            hit_cnt_q  <= '0;
`endif
        end else if (i_valid) begin
            if (i_last) begin
                state_q <= IDLE;
            end else begin
                state_q    <= ACCUM;
                best_hit_q <= best_hit_d;
                best_t_q   <= best_t_d;
                best_idx_q <= best_idx_d;
                tri_cnt_q  <= cur_idx + IDX_W'(1);
                ray_id_q   <= ray_id_d;
`ifdef CLOSEST_HIT_COUNT_EN
                hit_cnt_q  <= hit_cnt_d;
`endif
            end
        end
    end

    hit_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_push     (push),
        .i_data     (rec_d),
        .i_pop      (i_ready),
        .o_data     (head),
        .o_valid    (o_valid),
        .o_count    (fifo_count),
        .o_overflow (o_overflow)
    );

    assign o_full    = (fifo_count == CW'(FIFO_DEPTH));
    assign o_hit     = head.hit;
    assign o_t       = head.t;
    assign o_tri_idx = head.tri_idx;
    assign o_ray_id  = head.ray_id;
`ifdef CLOSEST_HIT_COUNT_EN
    assign o_hit_count = head.hit_count;
`endif

endmodule

// File: tb/tb_closest_hit_reducer.sv
// Bench for closest_hit_reducer: directed rays plus random traffic against a list-based reference model.
// Build with CLOSEST_HIT_COUNT_EN defined to also check o_hit_count.
module tb_closest_hit_reducer;

    localparam int IDX_W = 16;
    localparam int ID_W  = 8;
    localparam int DEPTH = 2;
    // Expected record packing: {hit_count, ray_id, tri_idx, t, hit}
    localparam int W     = IDX_W + ID_W + IDX_W + 32 + 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_valid = 1'b0;
    logic [31:0]       i_t = '0;
    logic              i_result = 1'b0;
    logic              i_last = 1'b0;
    logic [ID_W-1:0]   i_ray_id = '0;
    logic              i_ready = 1'b0;
    logic              o_full;
    logic              o_overflow;
    logic              o_valid;
    logic              o_hit;
    logic [31:0]       o_t;
    logic [IDX_W-1:0]  o_tri_idx;
    logic [ID_W-1:0]   o_ray_id;
`ifdef CLOSEST_HIT_COUNT_EN
    logic [IDX_W-1:0]  o_hit_count;
`endif

    closest_hit_reducer #(
        .IDX_W      (IDX_W),
        .ID_W       (ID_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (i_valid),
        .i_t        (i_t),
        .i_result   (i_result),
        .i_last     (i_last),
        .i_ray_id   (i_ray_id),
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_hit      (o_hit),
        .o_t        (o_t),
        .o_tri_idx  (o_tri_idx),
        .o_ray_id   (o_ray_id)
`ifdef CLOSEST_HIT_COUNT_EN
        ,
        .o_hit_count (o_hit_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]       exp_q[$];
    logic signed [31:0] ray_t[$];
    bit                 ray_r[$];
    logic [ID_W-1:0]    ray_id_m;
    bit                 ovf_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Closest hit over the whole ray: smallest t among hits, earliest index on ties.
    function automatic logic [W-1:0] reduce_ray();
        bit                 hit = 1'b0;
        logic signed [31:0] best = 32'sh7fff_ffff;
        int                 idx = 0;
        int                 hc = 0;
        for (int i = 0; i < ray_t.size(); i++) begin
            if (ray_r[i]) begin
                hc++;
                if (ray_t[i] < best) begin
                    hit  = 1'b1;
                    best = ray_t[i];
                    idx  = i;
                end
            end
        end
        return {hc[IDX_W-1:0], ray_id_m, idx[IDX_W-1:0], best, hit};
    endfunction

    task automatic check_outputs();
        logic [W-1:0] rec;
        check("valid", 64'(o_valid), 64'(exp_q.size() != 0));
        check("full", 64'(o_full), 64'(exp_q.size() == DEPTH));
        check("overflow", 64'(o_overflow), 64'(ovf_m));
        if (exp_q.size() != 0) begin
            rec = exp_q[0];
            check("hit", 64'(o_hit), 64'(rec[0]));
            check("t", 64'(o_t), 64'(rec[32:1]));
            check("tri_idx", 64'(o_tri_idx), 64'(rec[48:33]));
            check("ray_id", 64'(o_ray_id), 64'(rec[56:49]));
`ifdef CLOSEST_HIT_COUNT_EN
            check("hit_count", 64'(o_hit_count), 64'(rec[72:57]));
`endif
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [W-1:0] rec = '0;
        bit           push = 1'b0;
        if (i_valid) begin
            if (ray_t.size() == 0) ray_id_m = i_ray_id;
            ray_t.push_back(i_t);
            ray_r.push_back(i_result);
            if (i_last) begin
                rec  = reduce_ray();
                push = 1'b1;
                ray_t.delete();
                ray_r.delete();
            end
        end
        if (i_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else ovf_m = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tri(input logic [31:0] t, input bit res, input bit last, input logic [ID_W-1:0] id);
        i_valid  = 1'b1;
        i_t      = t;
        i_result = res;
        i_last   = last;
        i_ray_id = id;
        step();
        i_valid  = 1'b0;
        i_last   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_full"}, 64'(o_full), 64'd0);
        check({tag, "_overflow"}, 64'(o_overflow), 64'd0);
        check({tag, "_hit"}, 64'(o_hit), 64'd0);
        check({tag, "_t"}, 64'(o_t), 64'd0);
        check({tag, "_tri_idx"}, 64'(o_tri_idx), 64'd0);
        check({tag, "_ray_id"}, 64'(o_ray_id), 64'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic pulse_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero(tag);
        exp_q.delete();
        ray_t.delete();
        ray_r.delete();
        ovf_m = 1'b0;
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Three hits, closest in the middle.
        i_ready = 1'b0;
        send_tri(32'h30000, 1'b1, 1'b0, 8'd5);
        send_tri(32'h10000, 1'b1, 1'b0, 8'd77);
        send_tri(32'h20000, 1'b1, 1'b1, 8'd78);
        check("ray1_valid", 64'(o_valid), 64'd1);
        check("ray1_hit", 64'(o_hit), 64'd1);
        check("ray1_t", 64'(o_t), 64'h10000);
        check("ray1_idx", 64'(o_tri_idx), 64'd1);
        check("ray1_id", 64'(o_ray_id), 64'd5);
        i_ready = 1'b1;
        idle(2);

        // All misses, then a tie.
        for (int i = 0; i < 4; i++) send_tri(32'h1000 * (i + 1), 1'b0, i == 3, 8'd6);
        check("miss_t", 64'(o_t), 64'h7fffffff);
        check("miss_hit", 64'(o_hit), 64'd0);
        send_tri(32'h8000, 1'b1, 1'b0, 8'd7);
        send_tri(32'h9000, 1'b1, 1'b0, 8'd7);
        send_tri(32'h8000, 1'b1, 1'b1, 8'd7);
        check("tie_idx", 64'(o_tri_idx), 64'd0);

        // Back-to-back single-triangle rays.
        for (int i = 0; i < 6; i++) send_tri(32'h4000, 1'b1, 1'b1, 8'(20 + i));
        idle(2);

        // Three rays with no consumer: third is dropped.
        i_ready = 1'b0;
        send_tri(32'h100, 1'b1, 1'b1, 8'd31);
        send_tri(32'h200, 1'b1, 1'b1, 8'd32);
        check("full_after_2", 64'(o_full), 64'd1);
        send_tri(32'h300, 1'b1, 1'b1, 8'd33);
        check("ovf_after_3", 64'(o_overflow), 64'd1);
        idle(3);
        pulse_reset("rst1");

        // Full + pop + push on the same edge keeps both records.
        send_tri(32'h100, 1'b1, 1'b1, 8'd41);
        send_tri(32'h200, 1'b1, 1'b1, 8'd42);
        i_ready = 1'b1;
        send_tri(32'h300, 1'b1, 1'b1, 8'd43);
        check("pushpop_ovf", 64'(o_overflow), 64'd0);
        idle(3);

        // Reset mid-ray with a record waiting.
        i_ready = 1'b0;
        send_tri(32'h500, 1'b1, 1'b1, 8'd50);
        send_tri(32'h100, 1'b1, 1'b0, 8'd51);
        send_tri(32'h200, 1'b1, 1'b0, 8'd51);
        pulse_reset("rst2");
        send_tri(32'h700, 1'b1, 1'b0, 8'd9);
        send_tri(32'h900, 1'b1, 1'b1, 8'd10);
        check("post_rst_idx", 64'(o_tri_idx), 64'd0);
        check("post_rst_id", 64'(o_ray_id), 64'd9);
        i_ready = 1'b1;
        idle(2);

        // Five triangles, three hits.
        send_tri(32'h5000, 1'b1, 1'b0, 8'd60);
        send_tri(32'h1000, 1'b0, 1'b0, 8'd60);
        send_tri(32'h3000, 1'b1, 1'b0, 8'd60);
        send_tri(32'h2000, 1'b0, 1'b0, 8'd60);
        send_tri(32'h6000, 1'b1, 1'b1, 8'd60);
        check("hc_idx", 64'(o_tri_idx), 64'd2);
`ifdef CLOSEST_HIT_COUNT_EN
        check("hc_count", 64'(o_hit_count), 64'd3);
`endif
        idle(2);
        pulse_reset("rst3");

        // Random traffic, ties and negative t included.
        for (int i = 0; i < 400; i++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                send_tri(32'($urandom_range(0, 15)) * 32'h1000 - 32'h8000,
                         bit'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                         8'($urandom_range(0, 255)));
            end else begin
                idle(1);
            end
        end
        i_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
